// File: rtl/uart_apb_master.sv
// APB command sequencer for uart_apb: queues register commands in a small FIFO,
// issues each as a SETUP/ACCESS transfer and returns one response per command.
module uart_apb_master #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [9:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        sel,
    output logic [9:0]  addr,
    output logic        en,
    output logic        write_control,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    input  logic        ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full, empty, push, pop;

    state_t        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q;
    logic          sel_q, en_q, wc_q;
    logic [9:0]    addr_q;
    logic [31:0]   wdata_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    // Extra MSB on the pointers separates full from empty when low bits match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == IDLE) && !empty;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_ptr_q + PW'(1);
    assign rd_ptr_d = rd_ptr_q + PW'(1);
    assign cnt_d    = cnt_q + CW'(1);

    assign cmd_ready     = !full;
    assign busy          = !empty || (state_q != IDLE);
    assign sel           = sel_q;
    assign en            = en_q;
    assign write_control = wc_q;
    assign addr          = addr_q;
    assign write_data    = wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cmd_t'{cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_d;
            if (pop)  rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            wc_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= SETUP;
                        cnt_q   <= '0;
                        wr_q    <= head.wr;
                        sel_q   <= 1'b1;
                        wc_q    <= head.wr;
                        addr_q  <= head.addr;
                        wdata_q <= head.wr ? head.wdata : 32'd0;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    en_q    <= 1'b1;
                end
                ACCESS: begin
                    if (ready || (cnt_d == CW'(TIMEOUT))) begin
                        state_q     <= IDLE;
                        sel_q       <= 1'b0;
                        en_q        <= 1'b0;
                        wc_q        <= 1'b0;
                        addr_q      <= '0;
                        wdata_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !ready;
                        rsp_rdata_q <= (ready && !wr_q) ? read_data : 32'd0;
                    end
                    if (!ready) cnt_q <= cnt_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: latency, burst spacing, wait states,
// timeout, FIFO full/wrap and reset mid-transfer.
module tb_uart_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        sel;
    logic [9:0]  addr;
    logic        en;
    logic        write_control;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    uart_apb_master #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .sel(sel), .addr(addr), .en(en),
        .write_control(write_control), .write_data(write_data),
        .read_data(read_data), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int en_cyc = 0;

    int          su_cyc  [$];
    logic [9:0]  su_addr [$];
    logic [31:0] su_wd   [$];
    logic        su_wc   [$];
    logic [31:0] rs_data [$];
    logic        rs_err  [$];

    // Bus/response monitor, sampling away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (en) en_cyc <= en_cyc + 1;
        if (sel && !en) begin
            su_cyc.push_back(cyc);
            su_addr.push_back(addr);
            su_wd.push_back(write_data);
            su_wc.push_back(write_control);
        end
        if (rsp_valid) begin
            rs_data.push_back(rsp_rdata);
            rs_err.push_back(rsp_err);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_log();
        su_cyc.delete(); su_addr.delete(); su_wd.delete(); su_wc.delete();
        rs_data.delete(); rs_err.delete();
        en_cyc = 0;
    endtask

    task automatic push(input logic w, input logic [9:0] a,
                        input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        check("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        tick();
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic wait_en();
        int n = 0;
        while (!en && n < 50) begin
            tick();
            n++;
        end
        check("en_wait", 32'(en), 32'd1);
    endtask

    logic [9:0]  exp_a [5];
    logic [31:0] exp_d [5];

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        read_data = 32'hDEAD_BEEF;
        ready     = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_wc", 32'(write_control), 32'd0);
        check("rst_rspv", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", write_data, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_cmdrdy", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Single write, exact latency
        push(1'b1, 10'h004, 32'd16);
        check("w1_T_sel", 32'(sel), 32'd0);
        check("w1_T_busy", 32'(busy), 32'd1);
        tick();
        check("w1_su_sel", 32'(sel), 32'd1);
        check("w1_su_en", 32'(en), 32'd0);
        check("w1_su_addr", 32'(addr), 32'h004);
        check("w1_su_wd", write_data, 32'd16);
        check("w1_su_wc", 32'(write_control), 32'd1);
        tick();
        check("w1_ac_en", 32'(en), 32'd1);
        check("w1_ac_sel", 32'(sel), 32'd1);
        check("w1_ac_addr", 32'(addr), 32'h004);
        check("w1_ac_rspv", 32'(rsp_valid), 32'd0);
        tick();
        check("w1_rspv", 32'(rsp_valid), 32'd1);
        check("w1_err", 32'(rsp_err), 32'd0);
        check("w1_rdata", rsp_rdata, 32'd0);
        check("w1_sel0", 32'(sel), 32'd0);
        check("w1_en0", 32'(en), 32'd0);
        tick();
        check("w1_pulse", 32'(rsp_valid), 32'd0);
        check("w1_busy0", 32'(busy), 32'd0);

        // Config burst
        clear_log();
        exp_a[0] = 10'h004; exp_d[0] = 32'd16;
        exp_a[1] = 10'h002; exp_d[1] = 32'd0;
        exp_a[2] = 10'h001; exp_d[2] = 32'd1;
        exp_a[3] = 10'h000; exp_d[3] = 32'd53;
        for (int i = 0; i < 4; i++) push(1'b1, exp_a[i], exp_d[i]);
        wait_idle();
        check("burst_nsu", 32'(su_addr.size()), 32'd4);
        check("burst_nrsp", 32'(rs_err.size()), 32'd4);
        for (int i = 0; i < 4 && i < su_addr.size(); i++) begin
            check("burst_addr", 32'(su_addr[i]), 32'(exp_a[i]));
            check("burst_wd", su_wd[i], exp_d[i]);
        end
        for (int i = 1; i < su_cyc.size(); i++)
            check("burst_gap", 32'(su_cyc[i] - su_cyc[i-1]), 32'd3);
        for (int i = 0; i < rs_err.size(); i++)
            check("burst_err", 32'(rs_err[i]), 32'd0);

        // Read with three wait states
        clear_log();
        ready     = 1'b0;
        read_data = 32'h35;
        push(1'b0, 10'h000, 32'hFFFF_FFFF);
        wait_en();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_wait_en", 32'(en), 32'd1);
            check("rd_wait_rspv", 32'(rsp_valid), 32'd0);
        end
        ready = 1'b1;
        tick();
        check("rd_rspv", 32'(rsp_valid), 32'd1);
        check("rd_rdata", rsp_rdata, 32'h35);
        check("rd_err", 32'(rsp_err), 32'd0);
        check("rd_en0", 32'(en), 32'd0);
        check("rd_en_cycles", 32'(en_cyc), 32'd4);
        if (su_wc.size() > 0) begin
            check("rd_wc", 32'(su_wc[0]), 32'd0);
            check("rd_wd", su_wd[0], 32'd0);
        end
        wait_idle();

        // Timeout then next command
        clear_log();
        ready = 1'b0;
        push(1'b0, 10'h003, 32'd0);
        push(1'b1, 10'h005, 32'd7);
        wait_en();
        for (int i = 0; i < 15; i++) tick();
        check("to_pre_rspv", 32'(rsp_valid), 32'd0);
        check("to_pre_en", 32'(en), 32'd1);
        tick();
        check("to_rspv", 32'(rsp_valid), 32'd1);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_rdata", rsp_rdata, 32'd0);
        check("to_en0", 32'(en), 32'd0);
        ready = 1'b1;
        wait_idle();
        check("to_nrsp", 32'(rs_err.size()), 32'd2);
        if (rs_err.size() == 2) check("to_next_err", 32'(rs_err[1]), 32'd0);
        if (su_addr.size() == 2) check("to_next_addr", 32'(su_addr[1]), 32'h005);

        // FIFO full and pointer wrap
        clear_log();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_a[i] = 10'(10'h010 + i);
            exp_d[i] = 32'(100 + i);
            push(1'b1, exp_a[i], exp_d[i]);
        end
        check("full_cmdrdy", 32'(cmd_ready), 32'd0);
        check("full_en", 32'(en), 32'd1);
        check("full_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 10'h3FF;
        cmd_wdata = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_hold", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        ready     = 1'b1;
        wait_idle();
        check("full_nsu", 32'(su_addr.size()), 32'd5);
        check("full_nrsp", 32'(rs_err.size()), 32'd5);
        for (int i = 0; i < 5 && i < su_addr.size(); i++) begin
            check("full_addr", 32'(su_addr[i]), 32'(exp_a[i]));
            check("full_wd", su_wd[i], exp_d[i]);
        end

        // Reset mid-transfer
        clear_log();
        ready = 1'b0;
        push(1'b1, 10'h001, 32'd1);
        push(1'b1, 10'h002, 32'd2);
        push(1'b1, 10'h003, 32'd3);
        wait_en();
        rst = 1'b1;
        tick();
        check("mrst_sel", 32'(sel), 32'd0);
        check("mrst_en", 32'(en), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_rspv", 32'(rsp_valid), 32'd0);
        check("mrst_cmdrdy", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mrst_norsp", 32'(rs_err.size()), 32'd0);
        clear_log();
        push(1'b1, 10'h004, 32'd9);
        wait_idle();
        check("mrst_nrsp", 32'(rs_err.size()), 32'd1);
        if (rs_err.size() == 1) check("mrst_err", 32'(rs_err[0]), 32'd0);
        if (su_addr.size() == 1) begin
            check("mrst_addr", 32'(su_addr[0]), 32'h004);
            check("mrst_wd", su_wd[0], 32'd9);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
